// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller and its memory model.
package mem_stage_sram_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOW  = ST_LOW,
    HIGH = ST_HIGH,
    DONE = ST_DONE
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int unsigned DATA_BASE_ADDR  = 1024;
  localparam int          SRAM_AW_DEFAULT = 18;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline request/response and external SRAM signals of the MEM stage.
interface mem_stage_sram_ctrl_if
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEFAULT
) ();

  logic               mem_R_en;
  logic               mem_W_en;
  logic [31:0]        alu_result;
  logic [31:0]        val_rm;
  logic               ready;
  logic [31:0]        read_data;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_wdata;
  logic [15:0]        sram_rdata;
  logic               sram_we_n;
  logic               sram_oe_n;

  modport master (
    output mem_R_en, mem_W_en, alu_result, val_rm, sram_rdata,
    input  ready, read_data, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

  modport slave (
    input  mem_R_en, mem_W_en, alu_result, val_rm, sram_rdata,
    output ready, read_data, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/mem_stage_sram_wait_counter.sv
// Loadable up/down wait counter with a terminal-count flag for multi-cycle memory accesses.
module sram_wait_counter #(
  parameter int CW = 2
) (
  input  logic          clk_sys,
  input  logic          rst_b,
  input  logic          load,
  input  logic          en,
  input  logic          up,
  input  logic [CW-1:0] load_val,
  input  logic [CW-1:0] term,
  output logic          tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: each 32-bit load/store becomes two 16-bit async-SRAM accesses.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DATA_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = SRAM_AW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(WAIT_CYCLES - 1);

  state_e        state_q, state_d;
  op_e           op_q;
  logic [29:0]   idx_q;
  logic [31:0]   data_q;
  logic [31:0]   read_data_q;
  logic          req;
  logic          cnt_load, cnt_en, cnt_tc;
  logic          half;
  logic          active;

  assign req = bus.mem_R_en | bus.mem_W_en;

  sram_wait_counter #(.CW(CW)) u_wait (
    .clk_sys  (clk),
    .rst_b    (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .up       (1'b1),
    .load_val ('0),
    .term     (TERM),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_load = 1'b1;
        if (req) state_d = LOW;
      end
      LOW: begin
        if (cnt_tc) begin
          state_d  = HIGH;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_tc) begin
          state_d  = DONE;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        cnt_load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is captured only in IDLE, so EX/MEM may change freely while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_READ;
      idx_q  <= '0;
      data_q <= '0;
    end else if (state_q == IDLE && req) begin
      op_q   <= bus.mem_W_en ? OP_WRITE : OP_READ;
      idx_q  <= 30'((bus.alu_result - BASE_ADDR) >> 2);
      data_q <= bus.val_rm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q <= '0;
    end else if (op_q == OP_READ && cnt_tc) begin
      if (state_q == LOW)  read_data_q[15:0]  <= bus.sram_rdata;
      if (state_q == HIGH) read_data_q[31:16] <= bus.sram_rdata;
    end
  end

  assign active = (state_q == LOW) || (state_q == HIGH);
  assign half   = (state_q == HIGH);

  always_comb begin
    bus.ready      = 1'b0;
    bus.sram_we_n  = 1'b1;
    bus.sram_oe_n  = 1'b1;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (state_q == IDLE) bus.ready = ~req;
    if (state_q == DONE) bus.ready = 1'b1;
    if (active) begin
      bus.sram_addr = SRAM_AW'({idx_q, half});
      if (op_q == OP_WRITE) begin
        bus.sram_we_n  = 1'b0;
        bus.sram_wdata = half ? data_q[31:16] : data_q[15:0];
      end else begin
        bus.sram_oe_n = 1'b0;
      end
    end
  end

  assign bus.read_data = read_data_q;

endmodule
